zap_wb_tcm_slave: RTL



---
 rtl/zap_wb_pkg.sv | 33 +++
 rtl/zap_wb_tcm_slave_if.sv | 26 ++
 rtl/zap_wb_tcm_ram.sv | 27 ++
 rtl/zap_wb_tcm_slave.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/zap_wb_pkg.sv
// Shared Wishbone definitions for the ZAP data bus: cycle/burst type codes and the TCM slave FSM states.
package zap_wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK,
        ERR
    } tcm_state_e;

    // Index bits that increment and wrap inside a burst; zero means a linear burst.
    function automatic logic [3:0] wrapMask(input logic [1:0] bte);
        logic [3:0] mask;
        mask = 4'h0;
        case (bte)
            BTE_WRAP4:  mask = 4'h3;
            BTE_WRAP8:  mask = 4'h7;
            BTE_WRAP16: mask = 4'hF;
            default:    mask = 4'h0;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/zap_wb_tcm_slave_if.sv
// Wishbone B3 signal bundle between the ZAP memory stage (master) and the TCM responder (slave).
interface zap_wb_tcm_slave_if;

    logic        i_wb_cyc;
    logic        i_wb_stb;
    logic        i_wb_we;
    logic [31:0] i_wb_adr;
    logic [31:0] i_wb_dat;
    logic [3:0]  i_wb_sel;
    logic [2:0]  i_wb_cti;
    logic [1:0]  i_wb_bte;
    logic        o_wb_ack;
    logic        o_wb_err;
    logic [31:0] o_wb_dat;

    modport master (
        output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_adr, i_wb_dat, i_wb_sel, i_wb_cti, i_wb_bte,
        input  o_wb_ack, o_wb_err, o_wb_dat
    );

    modport slave (
        input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_adr, i_wb_dat, i_wb_sel, i_wb_cti, i_wb_bte,
        output o_wb_ack, o_wb_err, o_wb_dat
    );

endinterface

// File: rtl/zap_wb_tcm_ram.sv
// Single-port DEPTH_WORDS x 32 RAM with per-byte write enables and a registered read port.
module zap_wb_tcm_ram #(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic                           clk_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
    input  logic                           we_i,
    input  logic [3:0]                     be_i,
    input  logic [31:0]                    wdata_i,
    output logic [31:0]                    rdata_o
);

    logic [31:0] mem [DEPTH_WORDS];

    // Contents deliberately have no reset so they survive a core reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
        rdata_o <= mem[addr_i];
    end

endmodule

// File: rtl/zap_wb_tcm_slave.sv
// Wishbone B3 responder for the ZAP tightly-coupled data memory with wait states and range errors.
// Define ZAP_WB_TCM_BURST_EN to honour incrementing/wrapping bursts; otherwise cti/bte are ignored.
module zap_wb_tcm_slave
    import zap_wb_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    zap_wb_tcm_slave_if.slave bus
);

    localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    tcm_state_e       state_q, state_d;
    logic [3:0]       waitCnt_q, waitCnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             we_q, we_d;
    logic [3:0]       sel_q, sel_d;
    logic [31:0]      dat_q, dat_d;

    logic             reqValid;
    logic             inRange;
    logic [IDX_W-1:0] busIdx;
    logic [IDX_W-1:0] ramAddr;
    logic             ramWe;
    logic [3:0]       curSel;
    logic [31:0]      curDat;
    logic [31:0]      ramRdata;

    assign reqValid = bus.i_wb_cyc & bus.i_wb_stb;
    assign inRange  = (bus.i_wb_adr[31:IDX_W+2] == BASE_ADDR[31:IDX_W+2]);
    assign busIdx   = bus.i_wb_adr[IDX_W+1:2];

`ifdef ZAP_WB_TCM_BURST_EN
    logic [2:0] cti_q, cti_d;
    logic [1:0] bte_q, bte_d;
    logic       burstBeat_q, burstBeat_d;
    logic [2:0] curCti;
    logic       unusedBits;

    // Later burst beats present fresh data/sel/cti on the bus during their own ack cycle.
    assign curCti = burstBeat_q ? bus.i_wb_cti : cti_q;
    assign curSel = burstBeat_q ? bus.i_wb_sel : sel_q;
    assign curDat = burstBeat_q ? bus.i_wb_dat : dat_q;
    assign unusedBits = ^bus.i_wb_adr[1:0];

    function automatic logic [IDX_W-1:0] burstNext(input logic [IDX_W-1:0] idx, input logic [1:0] bte);
        logic [IDX_W-1:0] mask;
        logic [IDX_W-1:0] inc;
        mask = (bte == BTE_LINEAR) ? '1 : IDX_W'(wrapMask(bte));
        inc  = idx + IDX_W'(1);
        return (idx & ~mask) | (inc & mask);
    endfunction
`else
    logic unusedBits;

    assign curSel = sel_q;
    assign curDat = dat_q;
    assign unusedBits = ^{bus.i_wb_adr[1:0], bus.i_wb_cti, bus.i_wb_bte};
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= IDLE;
            waitCnt_q   <= '0;
            idx_q       <= '0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            dat_q       <= '0;
`ifdef ZAP_WB_TCM_BURST_EN
            cti_q       <= CTI_CLASSIC;
            bte_q       <= BTE_LINEAR;
            burstBeat_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            waitCnt_q   <= waitCnt_d;
            idx_q       <= idx_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            dat_q       <= dat_d;
`ifdef ZAP_WB_TCM_BURST_EN
            cti_q       <= cti_d;
            bte_q       <= bte_d;
            burstBeat_q <= burstBeat_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        waitCnt_d   = waitCnt_q;
        idx_d       = idx_q;
        we_d        = we_q;
        sel_d       = sel_q;
        dat_d       = dat_q;
`ifdef ZAP_WB_TCM_BURST_EN
        cti_d       = cti_q;
        bte_d       = bte_q;
        burstBeat_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (reqValid) begin
                    idx_d = busIdx;
                    we_d  = bus.i_wb_we;
                    sel_d = bus.i_wb_sel;
                    dat_d = bus.i_wb_dat;
`ifdef ZAP_WB_TCM_BURST_EN
                    cti_d = bus.i_wb_cti;
                    bte_d = bus.i_wb_bte;
`endif
                    if (!inRange) begin
                        state_d = ERR;
                    end else if (WAIT_STATES > 0) begin
                        state_d   = WAIT;
                        waitCnt_d = WAIT_LOAD;
                    end else begin
                        state_d = ACK;
                    end
                end
            end
            WAIT: begin
                if (!bus.i_wb_cyc) begin
                    state_d   = IDLE;
                    waitCnt_d = '0;
                end else if (waitCnt_q == 4'd0) begin
                    state_d = ACK;
                end else begin
                    waitCnt_d = waitCnt_q - 4'd1;
                end
            end
            ACK: begin
                state_d = IDLE;
`ifdef ZAP_WB_TCM_BURST_EN
                if (reqValid && curCti == CTI_INCR) begin
                    // A linear burst stepping past the last word has left the decoded window.
                    if (bte_q == BTE_LINEAR && (&idx_q)) begin
                        state_d = ERR;
                    end else begin
                        state_d     = ACK;
                        idx_d       = burstNext(idx_q, bte_q);
                        burstBeat_d = 1'b1;
                    end
                end
`endif
            end
            ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A write beat owns the single RAM port; otherwise it prefetches the word the next ack will return.
    assign ramWe   = (state_q == ACK) && we_q && !i_reset;
    assign ramAddr = ((state_q == ACK) && we_q) ? idx_q : idx_d;

    zap_wb_tcm_ram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_ram (
        .clk_i   (i_clk),
        .addr_i  (ramAddr),
        .we_i    (ramWe),
        .be_i    (curSel),
        .wdata_i (curDat),
        .rdata_o (ramRdata)
    );

    assign bus.o_wb_ack = (state_q == ACK);
    assign bus.o_wb_err = (state_q == ERR);
    assign bus.o_wb_dat = (state_q == ACK) ? ramRdata : 32'h0;

endmodule
